// File: rtl/wb_sched_pkg.sv
// Shared definitions for the writeback scheduler: default widths and source ids.
// Arbitration policy is selected with the WB_RR_ARB_EN macro (see wb_rr_arbiter).
package wb_sched_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int AREG_W_DEF = 5;

    // Source id doubles as the bit position in the arbiter request/grant vectors.
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-source writeback arbiter with a one-hot grant.
// WB_RR_ARB_EN defined: round-robin on contention; otherwise MEM has fixed priority over ALU.
module wb_rr_arbiter
    import wb_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] grant
);

`ifdef WB_RR_ARB_EN
    src_e last;

    // The pointer only moves when both sources compete, so a lone source never steals a turn.
    always_comb begin
        grant = req;
        if (req[SRC_ALU] && req[SRC_MEM]) begin
            grant = 2'b00;
            if (last == SRC_MEM) grant[SRC_ALU] = 1'b1;
            else                 grant[SRC_MEM] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= SRC_ALU;
        end else if (req[SRC_ALU] && req[SRC_MEM]) begin
            last <= (last == SRC_MEM) ? SRC_ALU : SRC_MEM;
        end
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    always_comb begin
        grant = req;
        if (req[SRC_MEM]) grant[SRC_ALU] = 1'b0;
    end
`endif

endmodule

// File: rtl/wb_sched.sv
// Writeback scheduler: one holding entry per result source, a pending-write scoreboard
// and a registered register-bank write port. Policy macro: WB_RR_ARB_EN.
module wb_sched
    import wb_sched_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int AREG_W = AREG_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              aluValid,
    output logic              aluReady,
    input  logic [AREG_W-1:0] aluRd,
    input  logic [DATA_W-1:0] aluData,
    input  logic              memValid,
    output logic              memReady,
    input  logic [AREG_W-1:0] memRd,
    input  logic [DATA_W-1:0] memData,
    input  logic              issueValid,
    input  logic [AREG_W-1:0] issueRd,
    input  logic [AREG_W-1:0] rs,
    input  logic [AREG_W-1:0] rt,
    output logic              rsBusy,
    output logic              rtBusy,
    output logic              wrReg,
    output logic [AREG_W-1:0] rd,
    output logic [DATA_W-1:0] rdIn
);

    localparam int NREG = 1 << AREG_W;

    logic              alu_full, mem_full;
    logic [AREG_W-1:0] alu_rd, mem_rd;
    logic [DATA_W-1:0] alu_data, mem_data;
    logic [NREG-1:0]   pending, pending_nxt;
    logic [1:0]        req, grant;
    logic              gnt_any;
    logic [AREG_W-1:0] gnt_rd;
    logic [DATA_W-1:0] gnt_data;

    assign req = {mem_full, alu_full};

    wb_rr_arbiter u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .grant (grant)
    );

    assign gnt_any  = |grant;
    assign gnt_rd   = grant[SRC_MEM] ? mem_rd   : alu_rd;
    assign gnt_data = grant[SRC_MEM] ? mem_data : alu_data;

    // An entry being drained this cycle can take a new result at the same edge.
    assign aluReady = !alu_full || grant[SRC_ALU];
    assign memReady = !mem_full || grant[SRC_MEM];

    assign rsBusy = (rs != '0) && pending[rs];
    assign rtBusy = (rt != '0) && pending[rt];

    // Set is applied after clear so a new producer issued at the grant edge keeps the bit.
    always_comb begin
        pending_nxt = pending;
        if (gnt_any) pending_nxt[gnt_rd] = 1'b0;
        if (issueValid && issueRd != '0) pending_nxt[issueRd] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_full <= 1'b0;
            alu_rd   <= '0;
            alu_data <= '0;
            mem_full <= 1'b0;
            mem_rd   <= '0;
            mem_data <= '0;
        end else begin
            if (aluValid && aluReady) begin
                alu_full <= 1'b1;
                alu_rd   <= aluRd;
                alu_data <= aluData;
            end else if (grant[SRC_ALU]) begin
                alu_full <= 1'b0;
            end
            if (memValid && memReady) begin
                mem_full <= 1'b1;
                mem_rd   <= memRd;
                mem_data <= memData;
            end else if (grant[SRC_MEM]) begin
                mem_full <= 1'b0;
            end
        end
    end

    // Writes to r0 are consumed here but never reach the bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrReg   <= 1'b0;
            rd      <= '0;
            rdIn    <= '0;
            pending <= '0;
        end else begin
            wrReg   <= gnt_any && (gnt_rd != '0);
            pending <= pending_nxt;
            if (gnt_any) begin
                rd   <= gnt_rd;
                rdIn <= gnt_data;
            end
        end
    end

endmodule

// File: doc/wb_sched.md
WB_SCHED -- requirements
Module: wb_sched

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter AREG_W, default 5, register address width (32 registers).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 aluValid  in  1  ALU result offered.
REQ-006 aluReady  out  1  ALU result accepted this cycle when aluValid&aluReady.
REQ-007 aluRd  in  AREG_W  ALU destination register.
REQ-008 aluData  in  DATA_W  ALU result.
REQ-009 memValid  in  1  load result offered.
REQ-010 memReady  out  1  load result accepted when memValid&memReady.
REQ-011 memRd  in  AREG_W  load destination register.
REQ-012 memData  in  DATA_W  load data.
REQ-013 issueValid  in  1  decode issues an instruction that writes issueRd.
REQ-014 issueRd  in  AREG_W  destination marked pending.
REQ-015 rs / rt  in  AREG_W each  source registers under hazard check.
REQ-016 rsBusy / rtBusy  out  1 each  source has an outstanding producer.
REQ-017 wrReg / rd / rdIn  out  1 / AREG_W / DATA_W  register-bank write port, registered.

Function
REQ-018 SHALL hold one entry per source (ALU, MEM): full flag, rd, data; handshake accepts into the entry at the edge.
REQ-019 xReady SHALL be high when entry x is empty or entry x is granted this cycle (1 write/cycle throughput per source).
REQ-020 Each cycle the arbiter SHALL grant at most one full entry; granted entry empties and its rd/data load into rd/rdIn at the same edge.
REQ-021 wrReg SHALL be high for exactly one cycle per grant with rd!=0; grant with rd==0 SHALL be consumed with wrReg low.
REQ-022 Uncontended latency: accepted at edge E -> wrReg high during the cycle after edge E+1.
REQ-023 Pending scoreboard: 32-bit mask; issueValid&issueRd!=0 sets bit; grant clears bit of granted rd at the same edge.
REQ-024 Same-edge set and clear of one bit SHALL leave it set (new producer wins).
REQ-025 rsBusy = pending[rs] combinationally, forced 0 when rs==0; rtBusy likewise; bit cleared when wrReg rises, bank forwarding covers that cycle.
REQ-026 Offered result with no matching pending bit SHALL still be written; scoreboard untouched.

Reset
REQ-027 rst SHALL immediately clear both entries, the pending mask, the arbiter pointer, wrReg, rd, rdIn to 0; aluReady/memReady read 1 after release.
REQ-028 Reset mid-operation SHALL drop held results silently; no write issued after release.

Configuration
REQ-029 With WB_RR_ARB_EN defined: round-robin; when both full, grant the source not granted last; pointer updates only on a contested grant.
REQ-030 Without WB_RR_ARB_EN: fixed priority, MEM over ALU; pointer absent.

Structure
REQ-031 Shared package SHALL hold DATA_W/AREG_W defaults and the source-id encoding (SRC_ALU=0, SRC_MEM=1).
REQ-032 Arbitration SHALL be sub-module wb_rr_arbiter (2 requests, grant one-hot, macro-controlled policy).

Verification
REQ-033 Reset then aluValid, aluRd=5, aluData=0xDEADBEEF one cycle -> wrReg=1, rd=5, rdIn=0xDEADBEEF exactly one cycle, 2 edges later.
REQ-034 Both valid same cycle, rd 3/4 (RR build) -> MEM, ALU, MEM, ALU order over repeated pairs; fixed build -> all MEM first, ALU stalled (aluReady=0).
REQ-035 issueRd=7; rs=7 -> rsBusy=1 until grant of rd=7; rsBusy=0 in the wrReg cycle.
REQ-036 issueRd=9 same edge as grant rd=9 -> pending[9] stays set, rtBusy=1 for rt=9.
REQ-037 aluRd=0 offered -> accepted, wrReg stays 0; rs=0 -> rsBusy=0 always.
REQ-038 rst pulse while both entries full -> no wrReg afterwards, busy flags 0, readies 1.
